// File: rtl/scroll_display_if.sv
// -----------------------------------------------------------------------------
// scroll_display_if
// Host and display-side signal bundle for scroll_display_ctrl.
//   master modport : host / testbench side (drives message and control inputs,
//                    observes window, scan and status outputs)
//   slave modport  : controller side
// Signals
//   wr_en, wr_addr[3:0], wr_data[3:0] : message buffer write port
//   msg_len[4:0]                      : message length, sampled on start
//   start, stop, pause                : scroll control (pause is a level)
//   thousands/hundreds/tens/ones[3:0] : 4-digit window onto the message
//   anode_n[3:0], seg_digit[3:0]      : multiplexed digit bus, active-low anodes
//   busy, wrap                        : scrolling active / position wrap pulse
// -----------------------------------------------------------------------------
interface scroll_display_if;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [3:0] wr_data;
   logic [4:0] msg_len;
   logic       start;
   logic       stop;
   logic       pause;
   logic [3:0] thousands;
   logic [3:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [3:0] anode_n;
   logic [3:0] seg_digit;
   logic       busy;
   logic       wrap;

   modport master (
      output wr_en, wr_addr, wr_data, msg_len, start, stop, pause,
      input  thousands, hundreds, tens, ones, anode_n, seg_digit, busy, wrap
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, msg_len, start, stop, pause,
      output thousands, hundreds, tens, ones, anode_n, seg_digit, busy, wrap
   );
endinterface

// File: rtl/scroll_display_ctrl.sv
// -----------------------------------------------------------------------------
// scroll_display_ctrl
// Sequencer for a 4-digit scrolling display. Stores a nibble message, steps a
// 4-digit window across it every SCROLL_DIV cycles and time-multiplexes the
// window onto one shared digit bus (one slot per REFRESH_DIV cycles).
// Ports
//   clk  : system clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : scroll_display_if.slave (message writes, control, window, scan, status)
// Parameters
//   MSG_DEPTH   : message entries (power of 2, 4..16)
//   SCROLL_DIV  : clk cycles per scroll step (>= 2)
//   REFRESH_DIV : clk cycles per digit scan slot (>= 2)
// Build option
//   SCROLL_BLANK_EN : when defined, the scroll cycle is L+4 positions long and
//                     positions >= L read as blank 4'hF, so the message scrolls
//                     fully off before it reappears. Undefined: circular scroll.
// -----------------------------------------------------------------------------
module scroll_display_ctrl #(
   parameter int MSG_DEPTH   = 16,
   parameter int SCROLL_DIV  = 50_000_000,
   parameter int REFRESH_DIV = 50_000
) (
   input logic            clk,
   input logic            rst,
   scroll_display_if.slave bus
);

`ifdef SCROLL_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   localparam int              AW           = $clog2(MSG_DEPTH);
   localparam int              SW           = $clog2(SCROLL_DIV);
   localparam int              RW           = $clog2(REFRESH_DIV);
   localparam logic [SW-1:0]   SCROLL_LAST  = SW'(SCROLL_DIV - 1);
   localparam logic [RW-1:0]   REFRESH_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [5:0]      GAP          = BLANK_EN ? 6'd4 : 6'd0;

   typedef enum logic [1:0] {IDLE, SCROLL, HOLD} state_t;

   state_t        state;
   logic [3:0]    mem [MSG_DEPTH];
   logic [4:0]    len;               // latched message length L
   logic [4:0]    pos;               // window position p
   logic [SW-1:0] scroll_cnt;
   logic [RW-1:0] refresh_cnt;
   logic [1:0]    scan_idx;
   logic [3:0]    win [4];           // 0 = ones .. 3 = thousands, matches anode bits
   logic [3:0]    anode_q;
   logic [3:0]    seg_q;
   logic          busy_q;
   logic          wrap_q;

   logic          restart;
   logic          tick;
   logic          step;
   logic          scan_step;
   logic [5:0]    cur_cycle;
   logic [5:0]    load_cycle;
   logic [4:0]    pos_next;
   logic [4:0]    load_pos;
   logic [4:0]    load_len;
   logic [1:0]    scan_next;
   logic [3:0]    win_next [4];

   // (a mod m) for a < m + 3; three conditional subtractions cover m down to 1.
   function automatic logic [5:0] wrap_idx(input logic [5:0] a, input logic [5:0] m);
      logic [5:0] r;
      r = a;
      for (int i = 0; i < 3; i++) begin
         if (r >= m) r = r - m;
      end
      return r;
   endfunction

   always_comb begin
      logic [5:0] idx;
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      idx        = '0;
      restart    = bus.start && !bus.stop && (bus.msg_len != 5'd0);
      tick       = !bus.stop && !restart && (state != IDLE) && !bus.pause;
      step       = tick && (scroll_cnt == SCROLL_LAST);
      cur_cycle  = {1'b0, len} + GAP;
      pos_next   = ({1'b0, pos} == cur_cycle - 6'd1) ? 5'd0 : pos + 5'd1;
      load_pos   = restart ? 5'd0 : pos_next;
      load_len   = restart ? bus.msg_len : len;
      load_cycle = {1'b0, load_len} + GAP;
      scan_step  = (refresh_cnt == REFRESH_LAST);
      scan_next  = scan_step ? scan_idx + 2'd1 : scan_idx;
      for (int i = 0; i < 4; i++) begin
         win_next[i] = win[i];
         if (restart || step) begin
            // win[i] shows window digit (3 - i): thousands is msg[p].
            idx = wrap_idx({1'b0, load_pos} + 6'(3 - i), load_cycle);
            win_next[i] = (BLANK_EN && (idx >= {1'b0, load_len})) ? 4'hF : mem[idx[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         len         <= '0;
         pos         <= '0;
         scroll_cnt  <= '0;
         refresh_cnt <= '0;
         scan_idx    <= '0;
         anode_q     <= 4'b1110;
         seg_q       <= '0;
         busy_q      <= 1'b0;
         wrap_q      <= 1'b0;
         for (int i = 0; i < 4; i++) win[i] <= '0;
         // NOTE: the message buffer is cleared on reset, so it is built from flops, not RAM.
         for (int i = 0; i < MSG_DEPTH; i++) mem[i] <= '0;
      end else begin
         // NOTE: non-blocking update, so a window loaded on this edge still sees the old entry.
         if (bus.wr_en && ({1'b0, bus.wr_addr} < 5'(MSG_DEPTH)))
            mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;

         wrap_q <= step && (pos_next == 5'd0);

         if (bus.stop) begin
            state  <= IDLE;
            busy_q <= 1'b0;
         end else if (restart) begin
            state      <= SCROLL;
            busy_q     <= 1'b1;
            len        <= bus.msg_len;
            pos        <= '0;
            scroll_cnt <= '0;
         end else if (state != IDLE) begin
            // HOLD is left on the edge pause drops, and that edge already counts.
            state <= bus.pause ? HOLD : SCROLL;
            if (tick) begin
               if (step) begin
                  scroll_cnt <= '0;
                  pos        <= pos_next;
               end else begin
                  scroll_cnt <= scroll_cnt + SW'(1);
               end
            end
         end

         for (int i = 0; i < 4; i++) win[i] <= win_next[i];

         // Scan runs in every state; seg_digit follows the window value that
         // becomes visible on this same edge so it never disagrees with anode_n.
         refresh_cnt <= scan_step ? '0 : refresh_cnt + RW'(1);
         scan_idx    <= scan_next;
         anode_q     <= ~(4'b0001 << scan_next);
         seg_q       <= win_next[scan_next];
      end
   end

   assign bus.thousands = win[3];
   assign bus.hundreds  = win[2];
   assign bus.tens      = win[1];
   assign bus.ones      = win[0];
   assign bus.anode_n   = anode_q;
   assign bus.seg_digit = seg_q;
   assign bus.busy      = busy_q;
   assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scroll_display_ctrl
// Self-checking bench for scroll_display_ctrl (MSG_DEPTH=16, SCROLL_DIV=4,
// REFRESH_DIV=2). Every clock edge is mirrored by a position/counter level
// reference model; directed vectors carry constant expected windows.
// Honours SCROLL_BLANK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_scroll_display_ctrl;
   localparam int MSG_DEPTH   = 16;
   localparam int SCROLL_DIV  = 4;
   localparam int REFRESH_DIV = 2;
`ifdef SCROLL_BLANK_EN
   localparam int GAP = 4;
`else
   localparam int GAP = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scroll_display_if bus();

   scroll_display_ctrl #(
      .MSG_DEPTH  (MSG_DEPTH),
      .SCROLL_DIV (SCROLL_DIV),
      .REFRESH_DIV(REFRESH_DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   logic [3:0] m_mem [MSG_DEPTH];
   logic [3:0] m_win [4];           // 0 = thousands .. 3 = ones
   int         m_len, m_pos, m_cnt, m_edges;
   bit         m_busy, m_wrap;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_load(input int p);
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (p + k) % (m_len + GAP);
         m_win[k] = (idx >= m_len) ? 4'hF : m_mem[idx];
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < MSG_DEPTH; i++) m_mem[i] = 4'h0;
         for (int k = 0; k < 4; k++) m_win[k] = 4'h0;
         m_len = 0; m_pos = 0; m_cnt = 0; m_edges = 0;
         m_busy = 1'b0; m_wrap = 1'b0;
         return;
      end
      m_wrap = 1'b0;
      if (bus.stop) begin
         m_busy = 1'b0;
      end else if (bus.start && bus.msg_len != 0) begin
         m_busy = 1'b1;
         m_len  = int'(bus.msg_len);
         m_pos  = 0;
         m_cnt  = 0;
         model_load(0);
      end else if (m_busy && !bus.pause) begin
         m_cnt++;
         if (m_cnt == SCROLL_DIV) begin
            m_cnt  = 0;
            m_pos  = (m_pos + 1) % (m_len + GAP);
            model_load(m_pos);
            m_wrap = (m_pos == 0);
         end
      end
      if (bus.wr_en && int'(bus.wr_addr) < MSG_DEPTH) m_mem[bus.wr_addr] = bus.wr_data;
      m_edges++;
   endtask

   function automatic logic [15:0] act_win();
      return {bus.thousands, bus.hundreds, bus.tens, bus.ones};
   endfunction

   // One clock: advance model on the edge, compare everything 1 time unit later.
   task automatic cycle();
      int s;
      logic [3:0] exp_an;
      @(posedge clk);
      model_edge();
      #1;
      s      = (m_edges / REFRESH_DIV) % 4;
      exp_an = 4'b1111 ^ (4'b0001 << s);
      check("model_window", 32'(act_win()), 32'({m_win[0], m_win[1], m_win[2], m_win[3]}));
      check("model_scan", 32'({bus.anode_n, bus.seg_digit}), 32'({exp_an, m_win[3 - s]}));
      check("model_flags", 32'({bus.busy, bus.wrap}), 32'({m_busy, m_wrap}));
   endtask

   task automatic clear_in();
      bus.wr_en = 1'b0; bus.wr_addr = 4'h0; bus.wr_data = 4'h0;
      bus.msg_len = 5'd0; bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit          start;
      bit          stop;
      bit          pause;
      logic [4:0]  len;
      int          n;        // edges the inputs are held for
      logic [15:0] win;
      bit          busy;
      bit          wrap;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [3:0] exp_an_seq [8];
      exp_an_seq = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110};

`ifndef SCROLL_BLANK_EN
      vecs.push_back('{1, 0, 0, 5'd8,  1, 16'h1234, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'h2345, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'h3456, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0, 16, 16'h7812, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'h8123, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'h1234, 1, 1});   // 8th step wraps
      vecs.push_back('{0, 0, 0, 5'd0,  1, 16'h1234, 1, 0});
      vecs.push_back('{0, 0, 1, 5'd0, 10, 16'h1234, 1, 0});   // paused, frozen
      vecs.push_back('{0, 0, 0, 5'd0,  2, 16'h1234, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  1, 16'h2345, 1, 0});   // remaining count honoured
      vecs.push_back('{0, 1, 0, 5'd0,  1, 16'h2345, 0, 0});   // stop, window held
      vecs.push_back('{0, 0, 0, 5'd0,  8, 16'h2345, 0, 0});
      vecs.push_back('{1, 1, 0, 5'd8,  1, 16'h2345, 0, 0});   // stop wins
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'h2345, 0, 0});
      vecs.push_back('{1, 0, 0, 5'd2,  1, 16'h1212, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'h2121, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'h1212, 1, 1});
      vecs.push_back('{1, 0, 0, 5'd1,  1, 16'h1111, 1, 0});   // restart while busy, L=1
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'h1111, 1, 1});
      vecs.push_back('{1, 0, 0, 5'd8,  1, 16'h1234, 1, 0});
      vecs.push_back('{0, 1, 0, 5'd0,  1, 16'h1234, 0, 0});
      vecs.push_back('{1, 0, 0, 5'd0,  1, 16'h1234, 0, 0});   // L=0 start ignored
`else
      vecs.push_back('{1, 0, 0, 5'd4,  1, 16'h1234, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'h234F, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'h34FF, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'h4FFF, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'hFFFF, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'hFFF1, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'hFF12, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'hF123, 1, 0});
      vecs.push_back('{0, 0, 0, 5'd0,  4, 16'h1234, 1, 1});
      vecs.push_back('{0, 1, 0, 5'd0,  1, 16'h1234, 0, 0});
`endif

      // ---- reset and idle scan ----
      clear_in();
      rst = 1'b1;
      repeat (3) cycle();
      check("rst_window", 32'(act_win()), 32'h0);
      check("rst_scan", 32'({bus.anode_n, bus.seg_digit}), 32'hE0);
      check("rst_flags", 32'({bus.busy, bus.wrap}), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         check($sformatf("idle_anode%0d", i), 32'(bus.anode_n), 32'(exp_an_seq[i]));
         check($sformatf("idle_busy%0d", i), 32'(bus.busy), 32'h0);
      end

      // ---- load message 1..8 ----
      for (int a = 0; a < 8; a++) begin
         bus.wr_en = 1'b1; bus.wr_addr = 4'(a); bus.wr_data = 4'(a + 1);
         cycle();
      end
      clear_in();

      // ---- table ----
      foreach (vecs[i]) begin
         bus.start = vecs[i].start; bus.stop = vecs[i].stop;
         bus.pause = vecs[i].pause; bus.msg_len = vecs[i].len;
         for (int c = 0; c < vecs[i].n; c++) cycle();
         check($sformatf("vec%0d_window", i), 32'(act_win()), 32'(vecs[i].win));
         check($sformatf("vec%0d_flags", i), 32'({bus.busy, bus.wrap}),
               32'({vecs[i].busy, vecs[i].wrap}));
         clear_in();
      end

      // ---- write colliding with the loading window ----
      bus.stop = 1'b1;
      cycle();
      clear_in();
      bus.start = 1'b1; bus.msg_len = 5'd4;
      bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 4'd9;
      cycle();
      clear_in();
      check("collide_old", 32'(act_win()), 32'h1234);
      repeat (4) cycle();
`ifndef SCROLL_BLANK_EN
      check("collide_new", 32'(act_win()), 32'h9341);
`else
      check("collide_new", 32'(act_win()), 32'h934F);
`endif

      // ---- reset mid-scroll overrides other inputs ----
      bus.start = 1'b1; bus.msg_len = 5'd8;
      cycle();
      clear_in();
      repeat (6) cycle();
      rst = 1'b1; bus.start = 1'b1; bus.pause = 1'b1; bus.msg_len = 5'd8;
      cycle();
      check("midrst_window", 32'(act_win()), 32'h0);
      check("midrst_scan", 32'({bus.anode_n, bus.seg_digit}), 32'hE0);
      check("midrst_flags", 32'({bus.busy, bus.wrap}), 32'h0);
      rst = 1'b0;
      clear_in();

      // ---- randomized run against the model ----
      for (int c = 0; c < 3000; c++) begin
         rst         = ($urandom_range(0, 499) == 0);
         bus.wr_en   = ($urandom_range(0, 2) == 0);
         bus.wr_addr = 4'($urandom_range(0, 15));
         bus.wr_data = 4'($urandom_range(0, 15));
         bus.msg_len = 5'($urandom_range(0, 16));
         bus.start   = ($urandom_range(0, 39) == 0);
         bus.stop    = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 19) == 0) bus.pause = ~bus.pause;
         cycle();
      end
      rst = 1'b0;
      clear_in();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
